// File: rtl/roba_fir_sequencer.sv
// roba_fir_sequencer: time-multiplexed FIR controller sharing one ROBA approximate multiplier across all taps.
// Optional macro ROBA_ROUND_NEAREST_EN: round operands to the nearest power of two (default: floor).
module roba_fir_sequencer #(
    parameter int DW   = 16,
    parameter int CW   = 16,
    parameter int TAPS = 8,
    parameter int ACCW = 40
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_wdata,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACCW-1:0]         out_data,
    output logic                    busy
);
    localparam int AW  = $clog2(TAPS);
    localparam int MW  = (DW > CW) ? DW : CW;
    localparam int PW  = $clog2(MW) + 1;
    localparam int PRW = DW + CW + 1;

    typedef enum logic [1:0] {IDLE, ROUND, MAC, DONE} state_t;

    state_t                  state_q;
    logic [TAPS-1:0][DW-1:0] x_q;
    logic [TAPS-1:0][CW-1:0] c_q;
    logic [AW-1:0]           tap_q;
    logic [ACCW-1:0]         acc_q, acc_d;
    logic [DW-1:0]           xm_q;
    logic [CW-1:0]           cm_q;
    logic [PW-1:0]           pa_q, pb_q;
    logic                    sgn_q, zero_q;
    logic                    out_valid_q, busy_q, in_ready_q;
    logic [ACCW-1:0]         out_data_q;

    // Leading-one position; the nearest variant bumps the exponent when the next bit down is set.
    function automatic logic [PW-1:0] lead_pos(input logic [MW-1:0] v);
        logic [PW-1:0] p;
`ifdef ROBA_ROUND_NEAREST_EN
        logic [PW-1:0] pm1;
        logic [MW-1:0] sh;
`endif
        p = '0;
        for (int i = 0; i < MW; i++)
            if (v[i]) p = PW'(i);
`ifdef ROBA_ROUND_NEAREST_EN
        pm1 = p - 1'b1;
        sh  = v >> pm1;
        if (p != '0 && sh[0]) p = p + 1'b1;
`endif
        return p;
    endfunction

    logic [DW-1:0] xs, xmag;
    logic [CW-1:0] cs, cmag;

    // -2^(DW-1) negates to itself, which read unsigned is the correct magnitude.
    always_comb begin
        xs   = x_q[tap_q];
        cs   = c_q[tap_q];
        xmag = xs[DW-1] ? (~xs + 1'b1) : xs;
        cmag = cs[CW-1] ? (~cs + 1'b1) : cs;
    end

    logic [PRW-1:0]  prod;
    logic [ACCW-1:0] pext;

    always_comb begin
        prod  = (PRW'(cm_q) << pa_q) + (PRW'(xm_q) << pb_q) - (PRW'(1) << (pa_q + pb_q));
        pext  = ACCW'(prod);
        acc_d = acc_q;
        if (!zero_q)
            acc_d = sgn_q ? (acc_q - pext) : (acc_q + pext);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            c_q         <= '0;
            tap_q       <= '0;
            acc_q       <= '0;
            xm_q        <= '0;
            cm_q        <= '0;
            pa_q        <= '0;
            pb_q        <= '0;
            sgn_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            if (coef_we && !busy_q && int'(coef_addr) < TAPS)
                c_q[coef_addr] <= coef_wdata;

            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_q        <= {x_q[TAPS-2:0], in_data};
                        acc_q      <= '0;
                        tap_q      <= '0;
                        state_q    <= ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ROUND: begin
                    xm_q    <= xmag;
                    cm_q    <= cmag;
                    pa_q    <= lead_pos(MW'(xmag));
                    pb_q    <= lead_pos(MW'(cmag));
                    sgn_q   <= xs[DW-1] ^ cs[CW-1];
                    zero_q  <= (xs == '0) || (cs == '0);
                    state_q <= MAC;
                end
                MAC: begin
                    acc_q <= acc_d;
                    if (tap_q == AW'(TAPS - 1)) begin
                        state_q     <= DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_data_q  <= acc_d;
                    end else begin
                        tap_q   <= tap_q + 1'b1;
                        state_q <= ROUND;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule

// File: doc/roba_fir_sequencer.md
Name: roba_fir_sequencer

Overview:
Time-multiplexed FIR controller that shares a single ROBA approximate multiplier stage across all taps. It accepts one input sample per valid/ready handshake and shifts it into a TAPS-deep delay line. It then walks the taps, computing each coefficient×sample product with leading-one rounding, shift-add and accumulate, and presents the filtered result on a valid/ready output.

Parameters:
DW, 16, sample width (signed two's complement)
CW, 16, coefficient width (signed two's complement)
TAPS, 8, number of taps (>=2)
ACCW, 40, accumulator/output width (signed)

Ports:
clk  in  1  clock
rst  in  1  reset
coef_we  in  1  coefficient write strobe
coef_addr  in  $clog2(TAPS)  coefficient index
coef_wdata  in  CW  coefficient value
in_valid  in  1  sample valid
in_ready  out  1  sample accepted when in_valid&&in_ready
in_data  in  DW  sample
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&&out_ready
out_data  out  ACCW  filtered result
busy  out  1  high in ROUND/MAC states

Behaviour:
- Reset is synchronous, active-high, on rst; clock is clk.
- Reset values: state=IDLE; delay line, coefficient bank, accumulator, out_data all 0; out_valid=0; busy=0; in_ready=1.
- States: IDLE, ROUND, MAC, DONE. in_ready = (state==IDLE).
- IDLE: on handshake at edge E0:
  - x[0]<=in_data and x[k]<=x[k-1];
  - acc<=0, tap<=0;
  - next state ROUND.
- ROUND (one cycle, the registered leading-one stage) registers, for x[tap] and c[tap]:
  - magnitudes |x|, |c|;
  - leading-one positions pa, pb;
  - sign = sx^sc;
  - zero flag = (x==0 || c==0).
- MAC computes approx product P = (|c|<<pa) + (|x|<<pb) - (1<<(pa+pb)) in DW+CW+1 unsigned bits.
  - Accumulation: acc += sign ? -P : P. Zero flag set -> adds 0.
  - If tap==TAPS-1, go to DONE; else tap++ and go to ROUND.
- Latency: tap k accumulates at edge E(2k+2). out_valid rises after edge E(2·TAPS), i.e. 16 cycles at default.
- DONE: out_valid=1, out_data=acc, both held stable until out_ready. On handshake, go to IDLE and drop out_valid the next cycle. No new sample is accepted until IDLE.
- Magnitude rule: -2^(DW-1) gives magnitude 2^(DW-1), which is valid.
- Floor rounding: Ar = 2^(leading-one position). The error is always >= 0 in magnitude, and powers of two are exact.
- Accumulator wraps modulo 2^ACCW; there is no saturation. out_data = acc sign-extended/truncated to ACCW.
- Coefficient writes:
  - Accepted only when busy=0 (IDLE or DONE); ignored while busy.
  - A write in DONE does not alter the held out_data.
- in_valid while not IDLE: not accepted; in_data is ignored.
- rst mid-operation (any state): immediate return to reset values. Delay line and coefficients are cleared and any partial result is discarded.

Optional Feature:
- Macro ROBA_ROUND_NEAREST_EN.
- Defined: round to nearest power of two. If position p>0 and bit p-1 is set, use p+1 (ties round up); the same P formula applies and the error may be signed.
- Undefined: floor rounding as above.
- Latency and interface are identical in both modes.

Test Plan:
1. Reset -> in_ready=1, out_valid=0, busy=0, out_data=0; a sample of 1 with all coefficients 0 -> out_data=0.
2. c0=3, others 0, sample 5 -> out_valid after exactly 16 edges post-handshake, out_data=14 (exact 15). With ROBA_ROUND_NEAREST_EN -> 16.
3. c0=4, sample -8 -> out_data=-32 (power-of-two exact); c0=-32768, sample 1 -> -32768.
4. c0=1, c1=2; samples 7 then 10 -> first out_data=7, second out_data=10+14=24; sample 0 contributes 0 (zero flag).
5. Hold out_ready=0 for 5 cycles in DONE -> out_valid/out_data stable, in_ready=0. A coef write during ROUND/MAC is ignored; a coef write in DONE is applied to the next sample.
6. Assert rst at the 5th edge after handshake -> next cycle state IDLE, out_valid=0, busy=0, coefficients read back as 0 (the next sample gives 0).
